// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache-side types for the cacheline adaptor: line/burst words and FSM states.
package cacheline_adaptor_pkg;

  localparam int BURST_BEATS = 4;
  localparam int CACHELINE_W = 256;

  typedef logic [CACHELINE_W-1:0] rv32i_cacheline;
  typedef logic [63:0]            rv32i_burst;

  typedef enum logic [1:0] {
    CLA_IDLE,
    CLA_RD,
    CLA_WR,
    CLA_DONE
  } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns whole-line cache requests into fixed-length memory
// bursts. Write lines are sliced into beats (lowest beat first); read beats are
// gathered into a line and returned with a one-cycle resp_o pulse.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = $bits(rv32i_cacheline),
  parameter int BURST_W = $bits(rv32i_burst)
) (
  input  logic               clk,
  input  logic               rst,
  // cache side
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  // memory side
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

  cla_state_t state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Holds the line being written, or the line being assembled during a read.
  logic [LINE_W-1:0]  buf_q, buf_d;
  logic [LINE_W-1:0]  line_d;
  logic [BURST_W-1:0] burst_d;
  logic [31:0]        addr_d;
  logic               read_d, write_d, resp_d;

  function automatic logic [31:0] align_line(input logic [31:0] addr);
    return addr & ADDR_MASK;
  endfunction

  function automatic logic [BURST_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                 input logic [CNT_W-1:0]  idx);
    return line[BURST_W*int'(idx) +: BURST_W];
  endfunction

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    line_d  = line_o;
    burst_d = burst_o;
    addr_d  = address_o;
    read_d  = 1'b0;
    write_d = 1'b0;
    resp_d  = 1'b0;

    unique case (state_q)
      CLA_IDLE: begin
        // Write is checked first so a simultaneous read+write resolves to the write.
        if (write_i) begin
          state_d = CLA_WR;
          buf_d   = line_i;
          addr_d  = align_line(address_i);
          burst_d = line_i[BURST_W-1:0];
          cnt_d   = '0;
          write_d = 1'b1;
        end else if (read_i) begin
          state_d = CLA_RD;
          addr_d  = align_line(address_i);
          cnt_d   = '0;
          read_d  = 1'b1;
        end
      end

      CLA_RD: begin
        read_d = 1'b1;
        if (resp_i) begin
          buf_d[BURST_W*int'(cnt_q) +: BURST_W] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            state_d = CLA_DONE;
            cnt_d   = '0;
            read_d  = 1'b0;
            resp_d  = 1'b1;
            line_d  = buf_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      CLA_WR: begin
        write_d = 1'b1;
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = CLA_DONE;
            cnt_d   = '0;
            write_d = 1'b0;
            resp_d  = 1'b1;
          end else begin
            // Present the next beat the cycle after the acknowledge.
            cnt_d   = cnt_q + CNT_W'(1);
            burst_d = beat_of(buf_q, cnt_d);
          end
        end
      end

      CLA_DONE: begin
        // Requests still high here are the tail of the finished transaction.
        state_d = CLA_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = CLA_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, data buffers and all outputs; reset clears everything, dropping any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLA_IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      line_o    <= line_d;
      burst_o   <= burst_d;
      address_o <= addr_d;
      read_o    <= read_d;
      write_o   <= write_d;
      resp_o    <= resp_d;
    end
  end

endmodule
